// File: rtl/dt_pkg.sv
// Shared constants and FSM state type for the distance-transform result packer.
package dt_pkg;

   localparam int unsigned IMG_W        = 128;
   localparam int unsigned IMG_PIX      = IMG_W * IMG_W;
   localparam int unsigned PIX_PER_WORD = 16;
   localparam int unsigned WORD_CNT     = IMG_PIX / PIX_PER_WORD;

   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned OADDR_W = 10;
   localparam int unsigned CNT_W   = 5;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      FIN
   } dt_state_t;

endpackage

// File: rtl/dt_bit_packer.sv
// Thresholds incoming result pixels and shifts them into a 16-bit word, MSB first.
module dt_bit_packer
   import dt_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        cap_en,
   input  logic [7:0]  din,
   input  logic [7:0]  thr,
   output logic [15:0] word,
   output logic        word_rdy
);

   logic [CNT_W-1:0] bit_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word    <= '0;
         bit_cnt <= '0;
      end else if (clr) begin
         word    <= '0;
         bit_cnt <= '0;
      end else if (cap_en) begin
         word    <= {word[14:0], (din > thr)};
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign word_rdy = (bit_cnt == CNT_W'(PIX_PER_WORD));

endmodule

// File: rtl/dt_res_pack.sv
// Packs the 128x128 result map into 1024 thresholded 16-bit words.
// Optional max-value tracking on port max_d is built only with DT_PACK_MAXD_EN.
module dt_res_pack
   import dt_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         thr,
   output logic               res_rd,
   output logic [ADDR_W-1:0]  res_addr,
   input  logic [7:0]         res_di,
   output logic               out_wr,
   output logic [OADDR_W-1:0] out_addr,
   output logic [15:0]        out_do,
`ifdef DT_PACK_MAXD_EN
   output logic [7:0]         max_d,
`endif
   output logic               busy,
   output logic               done
);

   dt_state_t          state, state_nxt;
   logic [CNT_W-1:0]   rd_cnt;
   logic [ADDR_W-1:0]  pix_addr;
   logic [OADDR_W-1:0] word_addr;
   logic [7:0]         thr_q;
   logic               rd_q;
   logic               start_acc;
   logic               pk_clr;
   logic [15:0]        pk_word;
   logic               pk_rdy;
   logic               last_word;

   assign start_acc = start && ((state == IDLE) || (state == FIN));
   assign last_word = (word_addr == OADDR_W'(WORD_CNT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, FIN: if (start) state_nxt = RD;
         // RD spans 16 read cycles plus one cycle for the last read's data
         RD:        if (rd_cnt == CNT_W'(PIX_PER_WORD)) state_nxt = WR;
         WR:        state_nxt = last_word ? FIN : RD;
         default:   state_nxt = IDLE;
      endcase
   end

   assign res_rd = (state == RD) && (rd_cnt < CNT_W'(PIX_PER_WORD));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt    <= '0;
         pix_addr  <= '0;
         word_addr <= '0;
         thr_q     <= '0;
         rd_q      <= 1'b0;
      end else begin
         rd_q <= res_rd;
         if (start_acc) begin
            thr_q     <= thr;
            rd_cnt    <= '0;
            pix_addr  <= '0;
            word_addr <= '0;
         end else if (state == RD) begin
            if (res_rd) begin
               rd_cnt <= rd_cnt + 1'b1;
               // hold at the final pixel; only a restart returns to address 0
               if (pix_addr != ADDR_W'(IMG_PIX - 1)) pix_addr <= pix_addr + 1'b1;
            end
         end else if (state == WR) begin
            rd_cnt <= '0;
            if (!last_word) word_addr <= word_addr + 1'b1;
         end
      end
   end

   assign pk_clr = start_acc || (state == WR);

   dt_bit_packer u_packer (
      .clk      (clk),
      .reset    (reset),
      .clr      (pk_clr),
      .cap_en   (rd_q),
      .din      (res_di),
      .thr      (thr_q),
      .word     (pk_word),
      .word_rdy (pk_rdy)
   );

   assign res_addr = pix_addr;
   assign out_addr = word_addr;
   assign out_wr   = (state == WR) && pk_rdy;
   assign out_do   = out_wr ? pk_word : '0;
   assign busy     = (state == RD) || (state == WR);
   assign done     = (state == FIN);

`ifdef DT_PACK_MAXD_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      max_d <= '0;
      else if (start_acc)              max_d <= '0;
      else if (rd_q && res_di > max_d) max_d <= res_di;
   end
`endif

endmodule
